// File: rtl/fp16_dot_accum.sv
// FP16 dot-product accumulator: sums four FP16 lanes per beat into an exact
// fixed-point accumulator (LSB = 2^-24) and emits one FP16 result per vector.
module fp16_dot_accum #(
    parameter int unsigned ACC_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [15:0]          a,
    input  logic [15:0]          b,
    input  logic [15:0]          c,
    input  logic [15:0]          d,
    output logic [15:0]          sum,
    output logic [ACC_WIDTH-1:0] acc_raw,
    output logic                 out_ovf,
    output logic                 out_valid
);
    localparam int unsigned AW     = ACC_WIDTH;
    localparam int unsigned TERM_W = 41;
    localparam int unsigned LSUM_W = 43;

    // Converts one FP16 value to a signed fixed-point term; inf/NaN map to 0.
    function automatic logic [TERM_W-1:0] unpack_term(input logic [15:0] x);
        logic [39:0] mag;
        mag = '0;
        if (x[14:10] == 5'd0)
            mag = 40'(x[9:0]);
        else if (x[14:10] != 5'd31)
            mag = 40'({1'b1, x[9:0]}) << (x[14:10] - 5'd1);
        return x[15] ? TERM_W'(-{1'b0, mag}) : {1'b0, mag};
    endfunction

    // Input capture and vector-start tracking
    logic             vec_start;
    logic             v0, l0, f0;
    logic [3:0][15:0] lanes0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_start <= 1'b1;
            v0        <= 1'b0;
            l0        <= 1'b0;
            f0        <= 1'b0;
            lanes0    <= '0;
        end else begin
            v0 <= in_valid;
            if (in_valid) begin
                l0        <= in_last;
                f0        <= vec_start;
                lanes0    <= {d, c, b, a};
                vec_start <= in_last;
            end
        end
    end

    // S1: unpack
    logic [3:0][TERM_W-1:0] term_c, term1;
    logic                   pinf_c, ninf_c;
    logic                   v1, l1, f1, pinf1, ninf1;

    always_comb begin
        pinf_c = 1'b0;
        ninf_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            term_c[i] = unpack_term(lanes0[i]);
            if (lanes0[i][14:10] == 5'd31) begin
                if (lanes0[i][15]) ninf_c = 1'b1;
                else               pinf_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0; l1 <= 1'b0; f1 <= 1'b0;
            pinf1 <= 1'b0; ninf1 <= 1'b0; term1 <= '0;
        end else begin
            v1 <= v0; l1 <= l0; f1 <= f0;
            pinf1 <= pinf_c; ninf1 <= ninf_c; term1 <= term_c;
        end
    end

    // S2: lane reduction
    logic [LSUM_W-1:0] lsum_c, lsum2;
    logic              v2, l2, f2, pinf2, ninf2;

    always_comb begin
        lsum_c = '0;
        for (int i = 0; i < 4; i++)
            lsum_c = lsum_c + LSUM_W'($signed(term1[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0; l2 <= 1'b0; f2 <= 1'b0;
            pinf2 <= 1'b0; ninf2 <= 1'b0; lsum2 <= '0;
        end else begin
            v2 <= v1; l2 <= l1; f2 <= f1;
            pinf2 <= pinf1; ninf2 <= ninf1; lsum2 <= lsum_c;
        end
    end

    // S3: accumulate with saturating wrap detection
    logic [AW-1:0] acc, acc_n, ext;
    logic [AW:0]   wide;
    logic          pinf3, ninf3, wrap3, fire3;
    logic          pinf_n, ninf_n, wrap_n;

    always_comb begin
        ext    = AW'($signed(lsum2));
        wide   = {acc[AW-1], acc} + {ext[AW-1], ext};
        acc_n  = acc;
        pinf_n = pinf3;
        ninf_n = ninf3;
        wrap_n = wrap3;
        if (v2) begin
            if (f2) begin
                acc_n  = ext;
                pinf_n = pinf2;
                ninf_n = ninf2;
                wrap_n = 1'b0;
            end else begin
                pinf_n = pinf3 | pinf2;
                ninf_n = ninf3 | ninf2;
                if (wide[AW] != wide[AW-1]) begin
                    wrap_n = 1'b1;
                    acc_n  = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                end else begin
                    acc_n  = wide[AW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0; pinf3 <= 1'b0; ninf3 <= 1'b0; wrap3 <= 1'b0; fire3 <= 1'b0;
        end else begin
            acc <= acc_n; pinf3 <= pinf_n; ninf3 <= ninf_n; wrap3 <= wrap_n;
            fire3 <= v2 & l2;
        end
    end

    // S4: normalise and pack the finished vector (truncate toward zero)
    logic [AW-1:0] mag;
    logic [5:0]    lead;
    logic [15:0]   sum_c;
    logic          ovf_c;

    always_comb begin
        mag   = acc[AW-1] ? -acc : acc;
        lead  = 6'd10;
        sum_c = 16'h0000;
        ovf_c = 1'b0;
        for (int i = 10; i < 40; i++)
            if (mag[i]) lead = 6'(i);
        if (pinf3 && ninf3) begin
            sum_c = 16'h7E00;
        end else if (pinf3) begin
            sum_c = 16'h7C00;
        end else if (ninf3) begin
            sum_c = 16'hFC00;
        end else if (wrap3 || (|mag[AW-1:40])) begin
            sum_c = {acc[AW-1], 15'h7C00};
            ovf_c = 1'b1;
        end else if (mag < AW'(1024)) begin
            sum_c = {acc[AW-1], 5'd0, mag[9:0]};
        end else begin
            sum_c = {acc[AW-1], 5'(lead - 6'd9), 10'(mag >> (lead - 6'd10))};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0; acc_raw <= '0; out_ovf <= 1'b0; out_valid <= 1'b0;
        end else begin
            out_valid <= fire3;
            if (fire3) begin
                sum     <= sum_c;
                acc_raw <= acc;
                out_ovf <= ovf_c;
            end
        end
    end
endmodule
